// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_chk_pkg;

    // Tracking state of the checker.
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Next value of a modulo counter running 0..max_val, then back to 0.
    function automatic logic [31:0] next_count(input logic [31:0] prev,
                                               input logic [31:0] max_val);
        return (prev == max_val) ? 32'd0 : prev + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle leave the counter at 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Clear first, then count, stopping at all-ones.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end
        if (inc && (q_d != '1)) begin
            q_d = q_d + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_seq_checker.sv
// Runtime checker for a free-running modulo counter: tracks lock, flags bad
// steps and out-of-range samples, and tallies wraps and errors.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int MAX_VAL  = 15,
    parameter int LOCK_CNT = 2,
    parameter int WRAP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_vld,
    input  logic              clear_err,
    output logic              locked,
    output logic              err_step,
    output logic              err_range,
    output logic              err_sticky,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WRAP_W-1:0] err_count
);

    localparam int               GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [GOOD_W-1:0] LOCK_W = GOOD_W'(LOCK_CNT);

    if (MAX_VAL >= (2 ** WIDTH)) begin : g_bad_max
        $error("MAX_VAL does not fit in WIDTH bits");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
        $error("LOCK_CNT must be at least 1");
    end

    state_e            state_d, state_q;
    logic [WIDTH-1:0]  prev_d, prev_q;
    logic [GOOD_W-1:0] good_d, good_q;
    logic              locked_d, locked_q;
    logic              err_step_d, err_step_q;
    logic              err_range_d, err_range_q;
    logic              err_sticky_d, err_sticky_q;
    logic              wrap_pulse_d, wrap_pulse_q;
    logic [WIDTH-1:0]  expected;
    logic              any_err;

    assign expected = WIDTH'(next_count(32'(prev_q), 32'(MAX_VAL)));
    assign any_err  = err_step_d | err_range_d;

    // Next-state and pulse decode; only valid samples advance anything.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        err_step_d   = 1'b0;
        err_range_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        if (count_vld) begin
            if (count_in > MAX_W) begin
                // Out-of-range samples are never trusted as a predecessor.
                err_range_d = 1'b1;
                good_d      = '0;
                state_d     = UNSYNC;
            end else begin
                prev_d = count_in;
                unique case (state_q)
                    UNSYNC: begin
                        good_d  = '0;
                        state_d = ACQ;
                    end
                    ACQ: begin
                        if (count_in == expected) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_d == LOCK_W) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (count_in == expected) begin
                            wrap_pulse_d = (prev_q == MAX_W);
                        end else begin
                            err_step_d = 1'b1;
                            good_d     = '0;
                            state_d    = ACQ;
                        end
                    end
                    default: begin
                        good_d  = '0;
                        state_d = UNSYNC;
                    end
                endcase
            end
        end
        locked_d     = (state_d == LOCKED);
        err_sticky_d = any_err ? 1'b1 : (clear_err ? 1'b0 : err_sticky_q);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNSYNC;
            prev_q       <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_step_q   <= 1'b0;
            err_range_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_step_q   <= err_step_d;
            err_range_q  <= err_range_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap_pulse_d),
        .clr   (1'b0),
        .q     (wrap_count)
    );

    sat_counter #(.W(WRAP_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (any_err),
        .clr   (clear_err),
        .q     (err_count)
    );

    assign locked     = locked_q;
    assign err_step   = err_step_q;
    assign err_range  = err_range_q;
    assign err_sticky = err_sticky_q;
    assign wrap_pulse = wrap_pulse_q;

`ifdef FORMAL
    logic [WRAP_W-1:0] wrap_prev_q;

    // Previous wrap tally for the monotonicity property.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_prev_q <= '0;
        end else begin
            wrap_prev_q <= wrap_count;
        end
    end

    // Structural invariants of the checker.
    always_comb begin
        if (rst_n) begin
            assert (!locked || (state_q == LOCKED));
            assert (!(err_step && err_range));
            assert (wrap_count >= wrap_prev_q);
        end
    end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: lock, step/range errors, gaps,
// clear priority, wrap saturation and asynchronous reset.
module tb_count_seq_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  count_in = '0;
    logic        count_vld = 1'b0;
    logic        clear_err = 1'b0;

    logic        locked, err_step, err_range, err_sticky, wrap_pulse;
    logic [15:0] wrap_count, err_count;
    logic        locked4, err_step4, err_range4, err_sticky4, wrap_pulse4;
    logic [3:0]  wrap_count4, err_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(6), .MAX_VAL(15), .LOCK_CNT(2), .WRAP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_vld(count_vld),
        .clear_err(clear_err), .locked(locked), .err_step(err_step),
        .err_range(err_range), .err_sticky(err_sticky), .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count), .err_count(err_count)
    );

    count_seq_checker #(.WIDTH(6), .MAX_VAL(15), .LOCK_CNT(2), .WRAP_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_vld(count_vld),
        .clear_err(clear_err), .locked(locked4), .err_step(err_step4),
        .err_range(err_range4), .err_sticky(err_sticky4), .wrap_pulse(wrap_pulse4),
        .wrap_count(wrap_count4), .err_count(err_count4)
    );

    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic drive(input logic vld, input logic [5:0] val, input logic clr);
        count_vld = vld;
        count_in  = val;
        clear_err = clr;
        @(posedge clk);
        #1;
        count_vld = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; count_vld = 1'b0; count_in = '0; clear_err = 1'b0;
        #2;
        checks++;
        if ({locked, err_step, err_range, err_sticky, wrap_pulse} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {locked, err_step, err_range, err_sticky, wrap_pulse});
        end
        checks++;
        if (wrap_count !== 16'd0 || err_count !== 16'd0) begin
            errors++; $display("FAIL reset_counts got wrap=%0d err=%0d exp 0 0", wrap_count, err_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lock_and_wrap();
        int pulses = 0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 6'(i % 16), 1'b0);
            pulses += int'(wrap_pulse);
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", locked); end
            end
            if (i == 2) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise got %b exp 1", locked); end
            end
            if (i == 16) begin
                checks++;
                if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse_at_0 got %b exp 1", wrap_pulse); end
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL wrap_pulse_count got %0d exp 1", pulses); end
        checks++;
        if (wrap_count !== 16'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", wrap_count); end
        checks++;
        if (err_sticky !== 1'b0 || err_count !== 16'd0) begin
            errors++; $display("FAIL lock_no_err got sticky=%b cnt=%0d exp 0 0", err_sticky, err_count);
        end
    endtask

    task automatic test_bad_step();
        for (int v = 2; v <= 7; v++) drive(1'b1, 6'(v), 1'b0);
        drive(1'b1, 6'd9, 1'b0);
        checks++;
        if ({err_step, err_range, err_sticky, locked} !== 4'b1010) begin
            errors++; $display("FAIL bad_step_flags got %b exp 1010", {err_step, err_range, err_sticky, locked});
        end
        checks++;
        if (err_count !== 16'd1) begin errors++; $display("FAIL bad_step_count got %0d exp 1", err_count); end
        drive(1'b1, 6'd10, 1'b0);
        checks++;
        if (err_step !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL reacq_10 got step=%b locked=%b exp 0 0", err_step, locked);
        end
        drive(1'b1, 6'd11, 1'b0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock_11 got %b exp 1", locked); end
    endtask

    task automatic test_range();
        drive(1'b0, 6'd0, 1'b1);
        checks++;
        if (err_sticky !== 1'b0 || err_count !== 16'd0) begin
            errors++; $display("FAIL clear_only got sticky=%b cnt=%0d exp 0 0", err_sticky, err_count);
        end
        drive(1'b1, 6'd20, 1'b0);
        checks++;
        if ({err_range, err_step, locked, err_sticky} !== 4'b1001) begin
            errors++; $display("FAIL range_flags got %b exp 1001", {err_range, err_step, locked, err_sticky});
        end
        drive(1'b1, 6'd3, 1'b0);
        drive(1'b1, 6'd4, 1'b0);
        checks++;
        if (locked !== 1'b0 || err_range !== 1'b0) begin
            errors++; $display("FAIL range_reacq got locked=%b range=%b exp 0 0", locked, err_range);
        end
        drive(1'b1, 6'd5, 1'b0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL range_relock got %b exp 1", locked); end
        checks++;
        if (err_count !== 16'd1) begin errors++; $display("FAIL range_count got %0d exp 1", err_count); end
    endtask

    task automatic test_gaps();
        test_reset();
        drive(1'b1, 6'd4, 1'b0);
        for (int g = 0; g < 3; g++) drive(1'b0, 6'd33, 1'b0);
        checks++;
        if ({locked, err_step, err_range, wrap_pulse} !== 4'b0) begin
            errors++; $display("FAIL gap_quiet got %b exp 0000", {locked, err_step, err_range, wrap_pulse});
        end
        drive(1'b1, 6'd5, 1'b0);
        drive(1'b0, 6'd1, 1'b0);
        drive(1'b1, 6'd6, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL gap_lock got locked=%b sticky=%b exp 1 0", locked, err_sticky);
        end
        drive(1'b0, 6'd50, 1'b0);
        drive(1'b0, 6'd2, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_step !== 1'b0) begin
            errors++; $display("FAIL gap_hold got locked=%b step=%b exp 1 0", locked, err_step);
        end
    endtask

    task automatic test_clear_vs_error();
        drive(1'b1, 6'd20, 1'b0);
        drive(1'b1, 6'd3, 1'b0);
        drive(1'b1, 6'd4, 1'b0);
        drive(1'b1, 6'd5, 1'b0);
        drive(1'b1, 6'd9, 1'b1);
        checks++;
        if (err_step !== 1'b1 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL clr_err_same got step=%b sticky=%b exp 1 1", err_step, err_sticky);
        end
        checks++;
        if (err_count !== 16'd1) begin errors++; $display("FAIL clr_err_count got %0d exp 1", err_count); end
        drive(1'b0, 6'd0, 1'b1);
        checks++;
        if (err_sticky !== 1'b0 || err_count !== 16'd0 || err_step !== 1'b0) begin
            errors++; $display("FAIL clr_after got sticky=%b cnt=%0d step=%b exp 0 0 0", err_sticky, err_count, err_step);
        end
    endtask

    task automatic test_wrap_sat_and_async_reset();
        test_reset();
        drive(1'b1, 6'd0, 1'b0);
        drive(1'b1, 6'd1, 1'b0);
        drive(1'b1, 6'd2, 1'b0);
        for (int k = 0; k < 320; k++) drive(1'b1, 6'((3 + k) % 16), 1'b0);
        checks++;
        if (wrap_count4 !== 4'hF) begin errors++; $display("FAIL wrap_sat4 got %0d exp 15", wrap_count4); end
        checks++;
        if (wrap_count !== 16'd20) begin errors++; $display("FAIL wrap_20 got %0d exp 20", wrap_count); end
        drive(1'b1, 6'd3, 1'b0);
        drive(1'b1, 6'd4, 1'b0);
        checks++;
        if (locked !== 1'b1 || locked4 !== 1'b1) begin
            errors++; $display("FAIL pre_rst_lock got %b%b exp 11", locked, locked4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, err_step, err_range, err_sticky, wrap_pulse, locked4} !== 6'b0 ||
            wrap_count !== 16'd0 || wrap_count4 !== 4'd0 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
            errors++; $display("FAIL async_reset got locked=%b wrap=%0d wrap4=%0d exp all 0", locked, wrap_count, wrap_count4);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_and_wrap();
        test_bad_step();
        test_range();
        test_gaps();
        test_clear_vs_error();
        test_wrap_sat_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
